// File: rtl/mult_acc_pkg.sv
// Shared types, default sizes and the add-clamp helper for the product accumulator.
package mult_acc_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ACC_W    = 24;
  localparam int DEF_NUM_PROD = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  // The wrapped sum is always available; a carry out only clamps when saturation is on.
  function automatic logic add_saturates(input logic carry, input logic sat_en);
    return carry & sat_en;
  endfunction

endpackage

// File: rtl/mult_acc_if.sv
// Product-in / result-out bus between the multiplier, the accumulator and its consumer.
interface mult_acc_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24
);
  logic [DATA_W-1:0] prod_in;
  logic              prod_ack;
  logic [ACC_W-1:0]  res_data;
  logic              res_valid;
  logic              res_ready;

  modport slave (
    input  prod_in, prod_ack, res_ready,
    output res_data, res_valid
  );

  modport master (
    output prod_in, prod_ack, res_ready,
    input  res_data, res_valid
  );
endinterface

// File: rtl/mult_acc_edge.sv
// Registers the multiplier ack and emits a one-cycle pulse on its rising edge.
module mult_acc_edge (
  input  logic clk,
  input  logic reset,
  input  logic ack,
  output logic pulse
);

  logic ack_q, ack_d;

  assign ack_d = ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ack_q <= 1'b0;
    else        ack_q <= ack_d;
  end

  assign pulse = ack & ~ack_q;

endmodule

// File: rtl/mult_acc.sv
// Accumulates NUM_PROD products into one result with a one-entry pending buffer.
// Build option: MULT_ACC_SAT_EN selects saturating instead of wrapping adds.
//   state | meaning
//   ACCUM | collecting products into acc
//   DONE  | result held on res_data until res_ready
module mult_acc
  import mult_acc_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int NUM_PROD = DEF_NUM_PROD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  mult_acc_if.slave  bus,
  output logic       busy,
  output logic       ovf_err,
  output logic       sat_flag
);

  localparam int              CNT_W      = $clog2(NUM_PROD + 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_PROD - 1);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
  localparam logic             FIRST_DONE = (NUM_PROD == 1);
`ifdef MULT_ACC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, res_q, res_d, pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_v_q, pend_v_d, ovf_q, ovf_d, sat_q, sat_d;
  logic              cap, carry, clamp, load_en;
  logic [ACC_W-1:0]  prod_ext, sum_wrap, sum, load_val;

  mult_acc_edge u_edge (
    .clk   (clk),
    .reset (reset),
    .ack   (bus.prod_ack),
    .pulse (cap)
  );

  assign prod_ext          = ACC_W'(bus.prod_in);
  assign {carry, sum_wrap} = {1'b0, acc_q} + {1'b0, prod_ext};
  assign clamp             = add_saturates(carry, SAT_EN);
  assign sum               = clamp ? {ACC_W{1'b1}} : sum_wrap;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ovf_d    = ovf_q;
    sat_d    = sat_q;
    load_en  = 1'b0;
    load_val = pend_q;
    if (clr) begin
      state_d  = ACCUM;
      acc_d    = '0;
      cnt_d    = '0;
      res_d    = '0;
      pend_v_d = 1'b0;
      ovf_d    = 1'b0;
      sat_d    = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (cap) begin
            sat_d = sat_q | clamp;
            if (cnt_q == LAST_CNT) begin
              state_d = DONE;
              res_d   = sum;
              acc_d   = '0;
              cnt_d   = '0;
            end else begin
              acc_d = sum;
              cnt_d = cnt_q + ONE_CNT;
            end
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state_d = ACCUM;
            if (pend_v_q) begin
              load_en  = 1'b1;
              load_val = pend_q;
              pend_v_d = cap;
              if (cap) pend_d = prod_ext;
            end else if (cap) begin
              load_en  = 1'b1;
              load_val = prod_ext;
            end
          end else if (cap) begin
            if (pend_v_q) begin
              ovf_d = 1'b1;
            end else begin
              pend_d   = prod_ext;
              pend_v_d = 1'b1;
            end
          end
        end
        default: state_d = ACCUM;
      endcase
      // A product starting a new set completes it at once when sets are one product long.
      if (load_en) begin
        if (FIRST_DONE) begin
          state_d = DONE;
          res_d   = load_val;
        end else begin
          acc_d = load_val;
          cnt_d = ONE_CNT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ovf_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ovf_q    <= ovf_d;
      sat_q    <= sat_d;
    end
  end

  assign bus.res_data  = res_q;
  assign bus.res_valid = (state_q == DONE);
  assign busy          = (cnt_q != '0) | bus.res_valid | pend_v_q;
  assign ovf_err       = ovf_q;
  assign sat_flag      = sat_q;

endmodule

// File: tb/tb_mult_acc.sv
// Directed bench for mult_acc: main 24-bit instance plus a 16-bit instance for wrap/saturation.
module tb_mult_acc;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0;
  logic busy1, ovf1, sat1, busy2, ovf2, sat2;
  int   checks = 0;
  int   errors = 0;

  mult_acc_if #(.DATA_W(16), .ACC_W(24)) b1 ();
  mult_acc_if #(.DATA_W(16), .ACC_W(16)) b2 ();

  mult_acc #(.DATA_W(16), .ACC_W(24), .NUM_PROD(4)) dut (
    .clk(clk), .reset(reset), .clr(clr), .bus(b1),
    .busy(busy1), .ovf_err(ovf1), .sat_flag(sat1)
  );

  mult_acc #(.DATA_W(16), .ACC_W(16), .NUM_PROD(4)) dut16 (
    .clk(clk), .reset(reset), .clr(clr), .bus(b2),
    .busy(busy2), .ovf_err(ovf2), .sat_flag(sat2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic capture(input int sel, input logic [15:0] v);
    if (sel == 1) begin b1.prod_in = v; b1.prod_ack = 1'b1; end
    else          begin b2.prod_in = v; b2.prod_ack = 1'b1; end
    tick();
    b1.prod_ack = 1'b0;
    b2.prod_ack = 1'b0;
  endtask

  task automatic send(input int sel, input logic [15:0] v);
    capture(sel, v);
    tick();
  endtask

  initial begin
    b1.prod_in = '0; b1.prod_ack = 1'b0; b1.res_ready = 1'b1;
    b2.prod_in = '0; b2.prod_ack = 1'b0; b2.res_ready = 1'b1;
    tick();
    check("rst_valid", 32'(b1.res_valid), 32'd0);
    check("rst_data", 32'(b1.res_data), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_ovf", 32'(ovf1), 32'd0);
    check("rst_sat", 32'(sat1), 32'd0);
    reset = 1'b1;
    tick();

    // basic set, consumer always ready
    send(1, 16'd30); send(1, 16'd140); send(1, 16'd40);
    capture(1, 16'd10);
    check("set1_valid", 32'(b1.res_valid), 32'd1);
    check("set1_data", 32'(b1.res_data), 32'd220);
    tick();
    check("set1_hs_valid", 32'(b1.res_valid), 32'd0);
    check("set1_idle", 32'(busy1), 32'd0);

    // long ack counts once
    b1.prod_in = 16'd30; b1.prod_ack = 1'b1;
    repeat (5) tick();
    check("hold_busy", 32'(busy1), 32'd1);
    check("hold_novalid", 32'(b1.res_valid), 32'd0);
    b1.prod_ack = 1'b0;
    tick();
    send(1, 16'd1); send(1, 16'd2);
    capture(1, 16'd3);
    check("hold_data", 32'(b1.res_data), 32'd36);
    check("hold_valid", 32'(b1.res_valid), 32'd1);
    tick();

    // stalled result: pend then drop
    b1.res_ready = 1'b0;
    send(1, 16'd30); send(1, 16'd140); send(1, 16'd40);
    capture(1, 16'd10);
    tick();
    check("stall_valid", 32'(b1.res_valid), 32'd1);
    send(1, 16'd7);
    check("pend_no_ovf", 32'(ovf1), 32'd0);
    send(1, 16'd9);
    check("drop_ovf", 32'(ovf1), 32'd1);
    check("stall_data", 32'(b1.res_data), 32'd220);
    b1.res_ready = 1'b1;
    tick();
    check("pend_hs_valid", 32'(b1.res_valid), 32'd0);
    check("pend_busy", 32'(busy1), 32'd1);
    send(1, 16'd1); send(1, 16'd1);
    capture(1, 16'd1);
    check("pend_set_data", 32'(b1.res_data), 32'd10);
    tick();
    check("ovf_sticky", 32'(ovf1), 32'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_ovf", 32'(ovf1), 32'd0);
    check("clr_data", 32'(b1.res_data), 32'd0);

    // handshake coincident with capture, pend empty
    b1.res_ready = 1'b0;
    send(1, 16'd1); send(1, 16'd2); send(1, 16'd3);
    capture(1, 16'd4);
    tick();
    check("hc_ready_data", 32'(b1.res_data), 32'd10);
    b1.res_ready = 1'b1; b1.prod_in = 16'd50; b1.prod_ack = 1'b1;
    tick();
    check("hc_valid", 32'(b1.res_valid), 32'd0);
    check("hc_busy", 32'(busy1), 32'd1);
    check("hc_ovf", 32'(ovf1), 32'd0);
    b1.prod_ack = 1'b0;
    tick();
    send(1, 16'd5); send(1, 16'd5);
    capture(1, 16'd5);
    check("hc_data", 32'(b1.res_data), 32'd65);
    tick();

    // capture during clr is discarded, held ack not recounted
    b1.prod_in = 16'd99; b1.prod_ack = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("clrcap_busy", 32'(busy1), 32'd0);
    b1.prod_ack = 1'b0;
    tick();
    send(1, 16'd1); send(1, 16'd2); send(1, 16'd3);
    capture(1, 16'd4);
    check("clrcap_data", 32'(b1.res_data), 32'd10);
    tick();

    // async reset mid-set
    send(1, 16'd100); send(1, 16'd70);
    check("pre_rst_busy", 32'(busy1), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_busy", 32'(busy1), 32'd0);
    check("async_data", 32'(b1.res_data), 32'd0);
    check("async_valid", 32'(b1.res_valid), 32'd0);
    #1 reset = 1'b1;
    tick();
    send(1, 16'd5); send(1, 16'd6); send(1, 16'd7);
    capture(1, 16'd8);
    check("post_rst_data", 32'(b1.res_data), 32'd26);
    tick();

    // 16-bit accumulator overflow
    send(2, 16'hFFFF); send(2, 16'h0002); send(2, 16'h0000);
    capture(2, 16'h0000);
    check("w16_valid", 32'(b2.res_valid), 32'd1);
`ifdef MULT_ACC_SAT_EN
    check("w16_data", 32'(b2.res_data), 32'h0000FFFF);
    check("w16_sat", 32'(sat2), 32'd1);
`else
    check("w16_data", 32'(b2.res_data), 32'h00000001);
    check("w16_sat", 32'(sat2), 32'd0);
`endif
    tick();
    check("w16_ovf", 32'(ovf2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
